// File: rtl/encoder_4to2_sync.sv
// Synchronous 4-to-2 priority encoder: synchronizes raw request lines, waits for a stable
// press, presents one encoded event under valid/ready, then waits for a stable release.
module encoder_4to2_sync #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] d,
   input  logic       ready,
   output logic [1:0] y,
   output logic       multi,
   output logic       valid,
   output logic       busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETTLE  = 2'd1;
   localparam logic [1:0] PRESENT = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [3:0] s1;
   logic [3:0] s2;
   logic [3:0] cap;
   logic [7:0] cnt;
   logic [1:0] state;
   logic [1:0] cap_idx;
   logic       cap_multi;

   // NOTE: non-blocking assignments make s2 take s1's previous value, giving two real flop stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 4'b0000;
         s2 <= 4'b0000;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      cap_idx   = 2'd0;
      cap_multi = ((cap & (cap - 4'd1)) != 4'd0);
      if (cap[3])      cap_idx = 2'd3;
      else if (cap[2]) cap_idx = 2'd2;
      else if (cap[1]) cap_idx = 2'd1;
   end

   // y and multi are loaded only on PRESENT entry so they stay stable after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cap   <= 4'b0000;
         cnt   <= 8'd0;
         y     <= 2'd0;
         multi <= 1'b0;
         valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && (s2 != 4'b0000)) begin
                  state <= SETTLE;
                  cap   <= s2;
                  cnt   <= 8'd1;
               end
            end
            SETTLE: begin
               if (!enable || (s2 == 4'b0000)) begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end else if (s2 != cap) begin
                  // A changed pattern restarts the count, even on the edge that would qualify.
                  cap <= s2;
                  cnt <= 8'd1;
               end else if (cnt == STABLE) begin
                  state <= PRESENT;
                  y     <= cap_idx;
                  multi <= cap_multi;
                  valid <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            PRESENT: begin
               if (ready) begin
                  state <= RELEASE;
                  valid <= 1'b0;
                  cnt   <= 8'd0;
               end
            end
            RELEASE: begin
               if (s2 != 4'b0000) begin
                  cnt <= 8'd0;
               end else if ((cnt + 8'd1) == STABLE) begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_encoder_4to2_sync.sv
// Directed bench for encoder_4to2_sync with STABLE_CYCLES = 4; inputs change and outputs
// are sampled on the falling clock edge.
module tb_encoder_4to2_sync;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] d;
   logic       ready;
   logic [1:0] y;
   logic       multi;
   logic       valid;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   encoder_4to2_sync #(.STABLE_CYCLES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .d      (d),
      .ready  (ready),
      .y      (y),
      .multi  (multi),
      .valid  (valid),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts falling edges until valid; a press from a quiet IDLE shows valid after edge 6,
   // which is the 7th falling edge after d changes.
   task automatic wait_valid(input string tag, input int exp_lat);
      int lat = 0;
      while (valid !== 1'b1 && lat < 40) begin
         tick(1);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         tick(1);
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic single_event(input string tag, input logic [3:0] val,
                               input logic [1:0] ey, input logic em);
      ready = 1'b1;
      d     = val;
      wait_valid(tag, 7);
      check({tag, "_y"}, 32'(y), 32'(ey));
      check({tag, "_multi"}, 32'(multi), 32'(em));
      tick(1);
      check({tag, "_one_cycle"}, 32'(valid), 32'd0);
      tick(4);
      check({tag, "_no_repeat"}, 32'(valid), 32'd0);
      d = 4'b0000;
      wait_idle(tag);
      check({tag, "_y_hold"}, 32'(y), 32'(ey));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_valid;
      logic seen_busy;
      logic stable;

      rst    = 1'b1;
      enable = 1'b1;
      d      = 4'b0000;
      ready  = 1'b0;
      tick(2);
      check("rst_y", 32'(y), 32'd0);
      check("rst_multi", 32'(multi), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick(3);

      // Asynchronous reset while an event is pending.
      d = 4'b0100;
      wait_valid("pre_rst", 7);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(valid), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_y", 32'(y), 32'd0);
      @(negedge clk);
      ready = 1'b1;
      rst   = 1'b0;
      tick(2);
      check("post_rst_busy_e1", 32'(busy), 32'd0);
      tick(1);
      check("post_rst_busy_e2", 32'(busy), 32'd1);
      tick(3);
      check("post_rst_valid_e5", 32'(valid), 32'd0);
      tick(1);
      check("post_rst_valid_e6", 32'(valid), 32'd1);
      check("post_rst_y", 32'(y), 32'd2);
      check("post_rst_multi", 32'(multi), 32'd0);
      tick(1);
      check("post_rst_one_cycle", 32'(valid), 32'd0);
      d = 4'b0000;
      tick(5);
      check("release_busy_r4", 32'(busy), 32'd1);
      tick(1);
      check("release_busy_r5", 32'(busy), 32'd0);

      // Each single line, then priority with more than one line set.
      single_event("line0", 4'b0001, 2'd0, 1'b0);
      single_event("line1", 4'b0010, 2'd1, 1'b0);
      single_event("line2", 4'b0100, 2'd2, 1'b0);
      single_event("line3", 4'b1000, 2'd3, 1'b0);
      single_event("pri_1010", 4'b1010, 2'd3, 1'b1);
      single_event("pri_0011", 4'b0011, 2'd1, 1'b1);

      // Bounce: 2-cycle toggling never settles long enough.
      seen_valid = 1'b0;
      for (int ph = 0; ph < 10; ph++) begin
         d = (ph % 2 == 0) ? 4'b0100 : 4'b0000;
         repeat (2) begin
            tick(1);
            seen_valid = seen_valid | valid;
         end
      end
      check("bounce_no_valid", 32'(seen_valid), 32'd0);
      single_event("bounce_hold", 4'b0100, 2'd2, 1'b0);

      // Backpressure: event held until ready, no repeat while the press is held.
      ready = 1'b0;
      d     = 4'b1000;
      wait_valid("bp", 7);
      stable = 1'b1;
      repeat (30) begin
         tick(1);
         if (valid !== 1'b1 || y !== 2'd3) stable = 1'b0;
      end
      check("bp_hold_stable", 32'(stable), 32'd1);
      ready = 1'b1;
      tick(1);
      check("bp_accept", 32'(valid), 32'd0);
      seen_valid = 1'b0;
      repeat (20) begin
         tick(1);
         seen_valid = seen_valid | valid;
      end
      check("bp_no_second", 32'(seen_valid), 32'd0);
      check("bp_busy_held", 32'(busy), 32'd1);
      d = 4'b0000;
      wait_idle("bp");
      single_event("bp_repress", 4'b0001, 2'd0, 1'b0);

      // Pattern change arriving on the would-be qualifying edge restarts the count.
      ready = 1'b1;
      d     = 4'b0100;
      tick(4);
      d = 4'b0001;
      tick(3);
      check("restart_valid_e6", 32'(valid), 32'd0);
      check("restart_busy_e6", 32'(busy), 32'd1);
      tick(3);
      check("restart_valid_e9", 32'(valid), 32'd0);
      tick(1);
      check("restart_valid_e10", 32'(valid), 32'd1);
      check("restart_y", 32'(y), 32'd0);
      tick(1);
      check("restart_accept", 32'(valid), 32'd0);
      d = 4'b0000;
      wait_idle("restart");

      // enable falling on the qualifying edge wins over entering PRESENT.
      d = 4'b0100;
      tick(6);
      check("en_abort_busy", 32'(busy), 32'd1);
      enable = 1'b0;
      tick(1);
      check("en_abort_valid", 32'(valid), 32'd0);
      check("en_abort_idle", 32'(busy), 32'd0);
      d = 4'b0000;
      tick(3);

      // Held request while disabled, then enable, then enable dropped in PRESENT.
      d          = 4'b0010;
      seen_valid = 1'b0;
      seen_busy  = 1'b0;
      repeat (20) begin
         tick(1);
         seen_valid = seen_valid | valid;
         seen_busy  = seen_busy | busy;
      end
      check("dis_no_valid", 32'(seen_valid), 32'd0);
      check("dis_no_busy", 32'(seen_busy), 32'd0);
      ready  = 1'b0;
      enable = 1'b1;
      tick(4);
      check("en_valid_e3", 32'(valid), 32'd0);
      tick(1);
      check("en_valid_e4", 32'(valid), 32'd1);
      check("en_y", 32'(y), 32'd1);
      enable = 1'b0;
      tick(5);
      check("en_drop_valid", 32'(valid), 32'd1);
      check("en_drop_y", 32'(y), 32'd1);
      ready = 1'b1;
      tick(1);
      check("en_drop_accept", 32'(valid), 32'd0);
      d = 4'b0000;
      wait_idle("en_drop");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
